// File: rtl/axi_rd_arb2.sv
// axi_rd_arb2: two-master round-robin AXI read arbiter with a registered AR stage
// and an in-order grant FIFO that steers R bursts back to their owning master.
module axi_rd_arb2 #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int OUTST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AW+21:0]           m0_ar_pld,
    input  logic                     m0_arvalid,
    output logic                     m0_arready,
    output logic [DW+5:0]            m0_r_pld,
    output logic                     m0_rlast,
    output logic                     m0_rvalid,
    input  logic                     m0_rready,
    input  logic [AW+21:0]           m1_ar_pld,
    input  logic                     m1_arvalid,
    output logic                     m1_arready,
    output logic [DW+5:0]            m1_r_pld,
    output logic                     m1_rlast,
    output logic                     m1_rvalid,
    input  logic                     m1_rready,
    output logic [AW+21:0]           s_ar_pld,
    output logic                     s_arvalid,
    input  logic                     s_arready,
    input  logic [DW+5:0]            s_r_pld,
    input  logic                     s_rlast,
    input  logic                     s_rvalid,
    output logic                     s_rready,
    output logic [$clog2(OUTST):0]   outst_cnt
);
    localparam int PW = $clog2(OUTST);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(OUTST);

    logic [AW+21:0] s_ar_pld_q;
    logic           s_arvalid_q;
    logic [OUTST-1:0] fifo_q;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           prio_q;
    logic           can_grant, gnt0, gnt1, grant, empty, head, pop, to0, to1;

    // Registered count is used on purpose: a same-cycle pop never frees a slot early.
    assign can_grant = rstn && (!s_arvalid_q || s_arready) && (cnt_q < FULL);
    assign gnt1      = can_grant && m1_arvalid && (!m0_arvalid || prio_q);
    assign gnt0      = can_grant && m0_arvalid && !gnt1;
    assign grant     = gnt0 || gnt1;
    assign m0_arready = gnt0;
    assign m1_arready = gnt1;

    assign empty = cnt_q == '0;
    assign head  = fifo_q[rd_ptr_q];
    assign to0   = !empty && !head;
    assign to1   = !empty && head;
    assign m0_rvalid = s_rvalid && to0;
    assign m1_rvalid = s_rvalid && to1;
    assign m0_r_pld  = to0 ? s_r_pld : '0;
    assign m1_r_pld  = to1 ? s_r_pld : '0;
    assign m0_rlast  = to0 && s_rlast;
    assign m1_rlast  = to1 && s_rlast;
    assign s_rready  = (to0 && m0_rready) || (to1 && m1_rready);
    assign pop       = s_rvalid && s_rready && s_rlast;
    assign cnt_d     = cnt_q + CW'(grant) - CW'(pop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_ar_pld_q  <= '0;
            s_arvalid_q <= 1'b0;
            fifo_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
        end else begin
            if (grant) begin
                s_ar_pld_q       <= gnt1 ? m1_ar_pld : m0_ar_pld;
                s_arvalid_q      <= 1'b1;
                fifo_q[wr_ptr_q] <= gnt1;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
                prio_q           <= gnt0;
            end else if (s_arready) begin
                s_arvalid_q <= 1'b0;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign s_ar_pld  = s_ar_pld_q;
    assign s_arvalid = s_arvalid_q;
    assign outst_cnt = cnt_q;
endmodule

// File: tb/tb_axi_rd_arb2.sv
// tb_axi_rd_arb2: directed bench with AR and R scoreboards for axi_rd_arb2.
module tb_axi_rd_arb2;
    logic        clk = 1'b0;
    logic        rstn;
    logic [53:0] m0_ar_pld, m1_ar_pld, s_ar_pld;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [37:0] m0_r_pld, m1_r_pld, s_r_pld;
    logic        m0_rlast, m0_rvalid, m0_rready, m1_rlast, m1_rvalid, m1_rready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic [2:0]  outst_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [53:0] ar_q[$];
    logic [38:0] r_q[$];
    logic [53:0] held;
    int          dm[4] = '{1, 0, 1, 1};

    axi_rd_arb2 dut (
        .clk(clk), .rstn(rstn),
        .m0_ar_pld(m0_ar_pld), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_r_pld(m0_r_pld), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_ar_pld(m1_ar_pld), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_r_pld(m1_r_pld), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_ar_pld(s_ar_pld), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_r_pld(s_r_pld), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .outst_cnt(outst_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] pl(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        return {id, a, len, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0};
    endfunction

    function automatic logic [37:0] rp(input int k);
        return {4'(k), 32'hD000_0000 + 32'(k), 2'(k)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one slave beat for master m; optionally stalls it for one cycle first.
    task automatic r_beat(input int m, input logic [37:0] d, input logic last, input logic stall);
        logic [38:0] e;
        s_r_pld = d; s_rlast = last; s_rvalid = 1'b1;
        r_q.push_back({last, d});
        if (stall) begin
            if (m == 1) m1_rready = 1'b0; else m0_rready = 1'b0;
            #1;
            chk("r_stall_srready", s_rready, 0);
            chk("r_stall_rvalid", m == 1 ? m1_rvalid : m0_rvalid, 1);
            @(posedge clk); #1;
            m0_rready = 1'b1; m1_rready = 1'b1;
            @(negedge clk);
        end
        #1;
        e = r_q.pop_front();
        chk("r_rvalid", m == 1 ? m1_rvalid : m0_rvalid, 1);
        chk("r_other_rvalid", m == 1 ? m0_rvalid : m1_rvalid, 0);
        chk("r_pld", m == 1 ? m1_r_pld : m0_r_pld, e[37:0]);
        chk("r_other_pld", m == 1 ? m0_r_pld : m1_r_pld, 0);
        chk("r_rlast", m == 1 ? m1_rlast : m0_rlast, e[38]);
        chk("r_srready", s_rready, 1);
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; m0_arvalid = 1'b1; m1_arvalid = 1'b0; s_arready = 1'b0;
        m0_ar_pld = pl(4'h1, 32'h1000, 4'h0); m1_ar_pld = '0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        s_r_pld = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_outst", outst_cnt, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        rstn = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m0_ar_pld = pl(4'h1, 32'h1000 + 32'(i * 16), 4'h0);
            m1_ar_pld = pl(4'h2, 32'h2000 + 32'(i * 16), 4'h0);
            ar_q.push_back(i % 2 == 1 ? m1_ar_pld : m0_ar_pld);
            #1;
            chk("cont_m0_arready", m0_arready, 64'(i % 2 == 0));
            chk("cont_m1_arready", m1_arready, 64'(i % 2 == 1));
            chk("cont_outst", outst_cnt, 64'(i));
            @(posedge clk); #1;
            chk("cont_s_arvalid", s_arvalid, 1);
            chk("cont_s_ar_pld", s_ar_pld, ar_q.pop_front());
            @(negedge clk);
        end
        #1;
        chk("full_m0_arready", m0_arready, 0);
        chk("full_m1_arready", m1_arready, 0);
        chk("full_outst", outst_cnt, 4);
        @(posedge clk); #1;
        chk("full_s_arvalid_drop", s_arvalid, 0);
        @(negedge clk);
        // Last beat and a pending request land in the same cycle.
        m0_arvalid = 1'b0; m1_ar_pld = pl(4'h2, 32'h2900, 4'h0);
        s_r_pld = rp(0); s_rlast = 1'b1; s_rvalid = 1'b1;
        #1;
        chk("fb_m1_arready_blocked", m1_arready, 0);
        chk("fb_m0_rvalid", m0_rvalid, 1);
        chk("fb_m0_r_pld", m0_r_pld, rp(0));
        chk("fb_m1_rvalid", m1_rvalid, 0);
        chk("fb_s_rready", s_rready, 1);
        @(posedge clk); #1;
        chk("fb_outst_3", outst_cnt, 3);
        s_rvalid = 1'b0; s_rlast = 1'b0;
        @(negedge clk); #1;
        chk("fb_m1_arready_next", m1_arready, 1);
        @(posedge clk); #1;
        chk("fb_outst_4", outst_cnt, 4);
        chk("fb_s_ar_pld", s_ar_pld, pl(4'h2, 32'h2900, 4'h0));
        m1_arvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            r_beat(dm[k], rp(k + 1), 1'b1, k == 1);
            chk("drain_outst", outst_cnt, 64'(3 - k));
        end
        s_rvalid = 1'b1; s_r_pld = rp(7);
        #1;
        chk("empty_s_rready", s_rready, 0);
        chk("empty_m0_rvalid", m0_rvalid, 0);
        chk("empty_m1_rvalid", m1_rvalid, 0);
        chk("empty_m0_pld", m0_r_pld, 0);
        @(posedge clk); #1;
        s_rvalid = 1'b0;
        @(negedge clk);
        s_arready = 1'b0; m0_arvalid = 1'b1; m0_ar_pld = pl(4'h3, 32'h3000, 4'h3);
        #1;
        chk("bp_m0_arready", m0_arready, 1);
        @(posedge clk); #1;
        held = pl(4'h3, 32'h3000, 4'h3);
        chk("bp_s_ar_pld", s_ar_pld, held);
        m0_ar_pld = pl(4'h3, 32'h3100, 4'h0);
        m1_arvalid = 1'b1; m1_ar_pld = pl(4'h4, 32'h4000, 4'h0);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_m0_arready_hold", m0_arready, 0);
            chk("bp_m1_arready_hold", m1_arready, 0);
            chk("bp_s_arvalid_hold", s_arvalid, 1);
            chk("bp_s_ar_pld_hold", s_ar_pld, held);
            @(posedge clk); #1;
        end
        @(negedge clk);
        s_arready = 1'b1;
        #1;
        chk("bp_release_m1_arready", m1_arready, 1);
        chk("bp_release_m0_arready", m0_arready, 0);
        @(posedge clk); #1;
        chk("bp_release_s_ar_pld", s_ar_pld, pl(4'h4, 32'h4000, 4'h0));
        chk("bp_release_outst", outst_cnt, 2);
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        @(negedge clk);
        r_beat(0, rp(10), 1'b0, 1'b0);
        r_beat(0, rp(11), 1'b0, 1'b1);
        r_beat(0, rp(12), 1'b0, 1'b0);
        chk("route_outst_mid", outst_cnt, 2);
        r_beat(0, rp(13), 1'b1, 1'b0);
        chk("route_outst_1", outst_cnt, 1);
        r_beat(1, rp(14), 1'b1, 1'b0);
        chk("route_outst_0", outst_cnt, 0);
        chk("route_s_arvalid_idle", s_arvalid, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
